control_tx: RTL and testbench
=============================

Name: control_tx

Overview:
- USB full-speed transmit packet controller.
- Mirrors the receive-side control FSM: on a request from the AHB slave, it sequences SYNC, PID, optional payload and CRC16 bytes to the bit serializer/NRZI encoder, then requests EOP.
- Pulls payload bytes from the shared 64-byte data buffer.
- Reports busy/error status back to the AHB slave.

Parameters:
- MAX_PAYLOAD, 64, maximum data bytes per packet; more requested bytes -> error.
- SYNC_BYTE, 8'h80, SYNC value presented (LSB transmitted first).

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
- tx_packet  in  4  packet type: 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL; any other value is invalid
- buffer_occupancy  in  7  bytes currently in the data buffer
- tx_fifo_data  in  8  head byte of the data buffer
- byte_done  in  1  serializer consumed tx_byte this cycle
- eop_done  in  1  encoder finished the EOP sequence
- tx_byte  out  8  byte offered to the serializer
- byte_valid  out  1  tx_byte is valid
- get_tx_data  out  1  pop one byte from the buffer
- send_eop  out  1  request EOP from the encoder
- tx_trans_active  out  1  packet in progress
- tx_error  out  1  sticky error flag, cleared by next accepted tx_start

Behaviour:
- Reset, synchronous on the clk edge while n_rst=0:
  - state=IDLE.
  - All outputs 0, including tx_byte=8'h00; tx_error=0; byte counter=0; CRC register=16'hFFFF.
  - Reset mid-packet aborts immediately; no EOP is issued.
- PID byte map:
  - DATA0=8'hC3, DATA1=8'h4B, ACK=8'hD2, NAK=8'h5A, STALL=8'h1E.
  - Latch tx_packet and the occupancy snapshot on the tx_start accept.
- States: IDLE, SYNC, PID, DATA, CRC1, CRC2, EOP, DONE, ERR.
- IDLE: tx_start=1 ->
  - if tx_packet is invalid, or the packet is DATA with occupancy snapshot > MAX_PAYLOAD -> ERR;
  - else -> SYNC.
  - Either way, clear tx_error on the accept.
- SYNC: tx_byte=SYNC_BYTE, byte_valid=1; byte_done -> PID.
- PID: tx_byte=PID byte; byte_done ->
  - ACK/NAK/STALL -> EOP;
  - DATA with count 0 -> CRC1 (zero-length packet);
  - DATA with count >0 -> DATA.
- DATA:
  - tx_byte=tx_fifo_data; byte_valid=1.
  - On byte_done: get_tx_data=1 the same cycle (combinational), CRC updated with the byte, remaining count decremented.
  - When the count reaches 0 -> CRC1.
  - If buffer_occupancy==0 while the count is >0 (underrun) -> ERR; no pop.
- CRC1: tx_byte = ~crc[7:0]; byte_done -> CRC2.
- CRC2: tx_byte = ~crc[15:8]; byte_done -> EOP.
- EOP: send_eop=1, byte_valid=0; eop_done -> DONE.
- DONE: one cycle, tx_trans_active=0 -> IDLE.
- ERR:
  - tx_error set; send_eop=1 so the line is released cleanly.
  - eop_done -> DONE.
- tx_trans_active=1 in every state except IDLE and DONE.
- Handshake rules:
  - byte_valid is high only in SYNC/PID/DATA/CRC1/CRC2.
  - tx_byte is stable while byte_valid=1 and byte_done=0.
  - byte_done seen when byte_valid=0 is ignored.
  - eop_done outside EOP/ERR is ignored.
- tx_start while busy is ignored; no queuing.
- Latency: tx_start at cycle N -> byte_valid with SYNC at N+1.
- CRC16 definition:
  - USB CRC16, polynomial x^16+x^15+x^2+1, init 16'hFFFF, bits processed LSB-first.
  - Reinitialised on the tx_start accept.
  - Empty payload gives CRC bytes 8'h00, 8'h00.

Optional Feature:
- Macro: TX_CRC_GEN_EN.
- Defined:
  - CRC16 is computed in hardware as described.
  - The data count includes payload bytes only.
- Undefined:
  - No CRC logic.
  - The host preloads the CRC as the last two buffer bytes.
  - CRC1/CRC2 present tx_fifo_data and pop like DATA.
  - The count covers payload+2; the error limit becomes MAX_PAYLOAD+2.
  - A DATA packet with snapshot <2 -> ERR.

Decomposition:
- Shared package usb_tx_pkg holds:
  - tx_state_t enum;
  - the packet-type codes;
  - the PID byte constants;
  - SYNC_BYTE default;
  - CRC16 polynomial/init constants.
- One sub-module, crc16_tx:
  - inputs clk, n_rst, clear, en, data[7:0];
  - output crc[15:0];
  - 8 bits per cycle, combinational unrolled;
  - instantiated only under TX_CRC_GEN_EN.

Test Plan:
- ACK: tx_start with tx_packet=3, byte_done every 8 cycles -> tx_byte sequence 80, D2; then send_eop; after eop_done, tx_trans_active falls; tx_error=0.
- DATA0 with 3 bytes 01 02 03 (occupancy 3) -> bytes 80, C3, 01, 02, 03, CRC low, CRC high matching the reference-model CRC16; exactly 3 get_tx_data pulses.
- DATA1 zero-length (occupancy 0) -> 80, 4B, 00, 00, then EOP; no get_tx_data pulses.
- Invalid tx_packet=4'hF -> ERR, tx_error=1, send_eop=1, no byte_valid; next valid tx_start clears tx_error.
- Occupancy drops to 0 after 2 of 5 bytes -> ERR, tx_error=1, EOP issued; reset asserted mid-DATA -> next cycle IDLE with all outputs 0.
- tx_start pulsed during DATA -> ignored; byte stream unchanged.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmit controller.
// Contents:
//   tx_state_t             - transmit FSM state encoding
//   PKT_*                  - tx_packet request codes from the AHB slave
//   PID_*                  - PID byte values put on the wire
//   SYNC_BYTE_DEF          - default SYNC pattern (LSB transmitted first)
//   CRC16_*                - USB CRC16 polynomial (normal and bit-reflected) and seed
//   pkt_valid / pkt_is_data / pid_byte - small decode helpers
package usb_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC1,
    CRC2,
    EOP,
    DONE,
    ERR
  } tx_state_t;

  localparam logic [3:0] PKT_DATA0 = 4'd1;
  localparam logic [3:0] PKT_DATA1 = 4'd2;
  localparam logic [3:0] PKT_ACK   = 4'd3;
  localparam logic [3:0] PKT_NAK   = 4'd4;
  localparam logic [3:0] PKT_STALL = 4'd5;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

  // x^16 + x^15 + x^2 + 1; the reflected form is what an LSB-first shifter uses.
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  function automatic logic pkt_valid(input logic [3:0] pkt);
    return (pkt >= PKT_DATA0) && (pkt <= PKT_STALL);
  endfunction

  function automatic logic pkt_is_data(input logic [3:0] pkt);
    return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] pkt);
    case (pkt)
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_ACK:   return PID_ACK;
      PKT_NAK:   return PID_NAK;
      PKT_STALL: return PID_STALL;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/control_tx_if.sv
// Handshake bundle between the transmit controller and its neighbours
// (AHB slave request/status, data buffer, serializer/NRZI encoder).
// Modports:
//   master - the controller: takes requests, buffer state and serializer
//            acknowledges; drives the byte stream, pop, EOP request, status.
//   slave  - the surrounding logic, opposite directions.
interface control_tx_if;
  logic       tx_start;
  logic [3:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_fifo_data;
  logic       byte_done;
  logic       eop_done;
  logic [7:0] tx_byte;
  logic       byte_valid;
  logic       get_tx_data;
  logic       send_eop;
  logic       tx_trans_active;
  logic       tx_error;

  modport master (
    input  tx_start, tx_packet, buffer_occupancy, tx_fifo_data, byte_done, eop_done,
    output tx_byte, byte_valid, get_tx_data, send_eop, tx_trans_active, tx_error
  );

  modport slave (
    output tx_start, tx_packet, buffer_occupancy, tx_fifo_data, byte_done, eop_done,
    input  tx_byte, byte_valid, get_tx_data, send_eop, tx_trans_active, tx_error
  );
endinterface

// File: rtl/crc16_tx.sv
// USB CRC16 accumulator, one byte per enabled cycle (8 bit steps unrolled).
// Ports:
//   clk, n_rst - clock, synchronous active-low reset (register -> 16'hFFFF)
//   clear      - reseed to 16'hFFFF (wins over en)
//   en         - fold data[7:0] into the register, LSB first
//   data       - byte to accumulate
//   crc        - current register value (transmit its complement)
module crc16_tx
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;
  logic [15:0] step;

  always_comb begin
    step = crc_reg;
    for (int i = 0; i < 8; i++) begin
      if (step[0] ^ data[i]) step = (step >> 1) ^ CRC16_POLY_REFL;
      else                   step = step >> 1;
    end
    crc_next = crc_reg;
    if (clear)   crc_next = CRC16_INIT;
    else if (en) crc_next = step;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) crc_reg <= CRC16_INIT;
    else        crc_reg <= crc_next;
  end

  assign crc = crc_reg;

endmodule

// File: rtl/control_tx.sv
// USB full-speed transmit packet controller. Sequences SYNC, PID, optional
// payload and CRC16 bytes to the serializer, then requests EOP.
// Ports:
//   clk   - system clock
//   n_rst - synchronous active-low reset; aborts a packet without EOP
//   bus   - control_tx_if.master: tx_start/tx_packet request, buffer
//           occupancy/head byte, byte_done/eop_done from the encoder;
//           tx_byte/byte_valid, get_tx_data, send_eop, tx_trans_active,
//           tx_error out.
// Parameters: MAX_PAYLOAD (data bytes per packet), SYNC_BYTE.
// Build option TX_CRC_GEN_EN: when defined the CRC16 is generated here and
// the byte count is payload only. When undefined the host preloads the CRC
// as the last two buffer bytes; CRC1/CRC2 then stream and pop the buffer,
// the count covers payload+2 and a DATA packet needs at least 2 bytes.
module control_tx
  import usb_tx_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 64,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
)(
  input  logic           clk,
  input  logic           n_rst,
  control_tx_if.master   bus
);

`ifdef TX_CRC_GEN_EN
  localparam logic [6:0] TAIL_CNT = 7'd0;
`else
  localparam logic [6:0] TAIL_CNT = 7'd2;
`endif
  localparam int LIMIT = MAX_PAYLOAD + int'(TAIL_CNT);

  tx_state_t  state_reg, state_next;
  logic [3:0] packet_reg, packet_next;
  logic [6:0] count_reg, count_next;
  logic       error_reg, error_next;
  logic       accept;
  logic       bad_len;

`ifdef TX_CRC_GEN_EN
  logic [15:0] crc;

  // Only payload pops reach the CRC in this build.
  crc16_tx u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (accept),
    .en    (bus.get_tx_data),
    .data  (bus.tx_fifo_data),
    .crc   (crc)
  );
`endif

  assign accept = (state_reg == IDLE) && bus.tx_start;

  always_comb begin
    bad_len = int'(bus.buffer_occupancy) > LIMIT;
`ifndef TX_CRC_GEN_EN
    bad_len = bad_len || (bus.buffer_occupancy < TAIL_CNT);
`endif
  end

  always_comb begin
    state_next          = state_reg;
    packet_next         = packet_reg;
    count_next          = count_reg;
    error_next          = error_reg;
    bus.tx_byte         = 8'h00;
    bus.byte_valid      = 1'b0;
    bus.get_tx_data     = 1'b0;
    bus.send_eop        = 1'b0;
    bus.tx_trans_active = 1'b1;

    case (state_reg)
      IDLE: begin
        bus.tx_trans_active = 1'b0;
        if (bus.tx_start) begin
          packet_next = bus.tx_packet;
          count_next  = bus.buffer_occupancy;
          if (!pkt_valid(bus.tx_packet) || (pkt_is_data(bus.tx_packet) && bad_len)) begin
            state_next = ERR;
            error_next = 1'b1;
          end else begin
            state_next = SYNC;
            error_next = 1'b0;
          end
        end
      end

      SYNC: begin
        bus.tx_byte    = SYNC_BYTE;
        bus.byte_valid = 1'b1;
        if (bus.byte_done) state_next = PID;
      end

      PID: begin
        bus.tx_byte    = pid_byte(packet_reg);
        bus.byte_valid = 1'b1;
        if (bus.byte_done) begin
          if (!pkt_is_data(packet_reg))  state_next = EOP;
          else if (count_reg == TAIL_CNT) state_next = CRC1;
          else                            state_next = DATA;
        end
      end

      DATA: begin
        bus.tx_byte    = bus.tx_fifo_data;
        bus.byte_valid = 1'b1;
        // An empty buffer mid-payload is an underrun; nothing is popped.
        if (bus.buffer_occupancy == 7'd0) begin
          state_next = ERR;
          error_next = 1'b1;
        end else if (bus.byte_done) begin
          bus.get_tx_data = 1'b1;
          count_next      = count_reg - 7'd1;
          if (count_reg == TAIL_CNT + 7'd1) state_next = CRC1;
        end
      end

`ifdef TX_CRC_GEN_EN
      CRC1: begin
        bus.tx_byte    = ~crc[7:0];
        bus.byte_valid = 1'b1;
        if (bus.byte_done) state_next = CRC2;
      end

      CRC2: begin
        bus.tx_byte    = ~crc[15:8];
        bus.byte_valid = 1'b1;
        if (bus.byte_done) state_next = EOP;
      end
`else
      // Host-supplied CRC bytes come straight out of the buffer.
      CRC1, CRC2: begin
        bus.tx_byte    = bus.tx_fifo_data;
        bus.byte_valid = 1'b1;
        if (bus.buffer_occupancy == 7'd0) begin
          state_next = ERR;
          error_next = 1'b1;
        end else if (bus.byte_done) begin
          bus.get_tx_data = 1'b1;
          count_next      = count_reg - 7'd1;
          state_next      = (state_reg == CRC1) ? CRC2 : EOP;
        end
      end
`endif

      EOP: begin
        bus.send_eop = 1'b1;
        if (bus.eop_done) state_next = DONE;
      end

      DONE: begin
        bus.tx_trans_active = 1'b0;
        state_next          = IDLE;
      end

      ERR: begin
        // Still finish with an EOP so the bus is left idle.
        bus.send_eop = 1'b1;
        error_next   = 1'b1;
        if (bus.eop_done) state_next = DONE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.tx_error = error_reg;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      packet_reg <= 4'd0;
      count_reg  <= 7'd0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      packet_reg <= packet_next;
      count_reg  <= count_next;
      error_reg  <= error_next;
    end
  end

endmodule

// File: tb/tb_control_tx.sv
// Directed bench for control_tx: a buffer model and a serializer/encoder
// responder (byte_done after 8 valid cycles, eop_done 3 cycles into EOP)
// capture the byte stream and pops; expectations come from hand-written
// tables plus a bitwise CRC16 reference. Follows the TX_CRC_GEN_EN build.
module tb_control_tx;
  import usb_tx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  control_tx_if bus();

  control_tx dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

`ifdef TX_CRC_GEN_EN
  localparam int LIMIT = 64;
`else
  localparam int LIMIT = 66;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo[$];
  logic [7:0] got[$];
  int pops;
  int first_valid;
  bit saw_eop, saw_valid, err_seen, timed_out;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[k][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic drive_fifo(input int occ_force, input bit forced_zero);
    if (forced_zero)         bus.buffer_occupancy = 7'd0;
    else if (occ_force >= 0) bus.buffer_occupancy = 7'(occ_force);
    else                     bus.buffer_occupancy = 7'(fifo.size());
    bus.tx_fifo_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  // Plays one packet. Ends at DONE (trans_active low after eop_done), or
  // right after a mid-packet reset when reset_after >= 0.
  task automatic run_pkt(input logic [3:0] pkt, input int occ_force, input int underrun_after,
                         input bit start_mid, input int reset_after);
    int vcnt = 0;
    int eop_cnt = 0;
    bit eop_given = 0;
    bit forced_zero = 0;
    bit mid_done = 0;
    bit pop_now, valid_s, eop_s;
    got.delete();
    pops = 0; first_valid = -1;
    saw_eop = 0; saw_valid = 0; err_seen = 0; timed_out = 1;
    @(posedge clk); #1;
    bus.tx_packet = pkt;
    bus.tx_start  = 1'b1;
    drive_fifo(occ_force, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      pop_now = bus.get_tx_data;
      valid_s = bus.byte_valid;
      eop_s   = bus.send_eop;
      if (pop_now) pops++;
      if (valid_s) begin
        saw_valid = 1;
        if (first_valid < 0) first_valid = cyc;
      end
      if (valid_s && bus.byte_done) begin
        got.push_back(bus.tx_byte);
        vcnt = 0;
      end else if (valid_s) begin
        vcnt++;
      end
      if (eop_s) begin
        saw_eop = 1;
        eop_cnt++;
      end
      if (bus.tx_error) err_seen = 1;
      if (eop_given && !bus.tx_trans_active) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
      bus.tx_start  = 1'b0;
      bus.byte_done = 1'b0;
      bus.eop_done  = 1'b0;
      if (reset_after >= 0 && got.size() >= reset_after) begin
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        timed_out = 0;
        return;
      end
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      if (underrun_after >= 0 && pops >= underrun_after) forced_zero = 1;
      drive_fifo(occ_force, forced_zero);
      if (valid_s && vcnt == 7) bus.byte_done = 1'b1;
      if (eop_s && eop_cnt == 3 && !eop_given) begin
        bus.eop_done = 1'b1;
        eop_given    = 1;
      end
      if (start_mid && !mid_done && got.size() == 3) begin
        bus.tx_start  = 1'b1;
        bus.tx_packet = PKT_ACK;
        mid_done      = 1;
      end
    end
    bus.byte_done = 1'b0;
    bus.eop_done  = 1'b0;
    $display("[TB] packet %0h: %0d bytes, %0d pops, eop=%0b, err=%0b", pkt, got.size(), pops,
             saw_eop, bus.tx_error);
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp[$]);
    check({name, " len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s byte%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, exp[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp[$];
    logic [7:0]  pay[$];
    logic [15:0] c;
    bit          idle_bad;

    n_rst = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_packet = 4'd0;
    bus.buffer_occupancy = 7'd0;
    bus.tx_fifo_data = 8'h00;
    bus.byte_done = 1'b0;
    bus.eop_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst tx_byte", bus.tx_byte, 8'h00);
    check("rst byte_valid", bus.byte_valid, 1'b0);
    check("rst get_tx_data", bus.get_tx_data, 1'b0);
    check("rst send_eop", bus.send_eop, 1'b0);
    check("rst active", bus.tx_trans_active, 1'b0);
    check("rst tx_error", bus.tx_error, 1'b0);

    // ACK handshake packet
    fifo.delete();
    run_pkt(PKT_ACK, -1, -1, 0, -1);
    check("ack done", timed_out, 0);
    exp = '{8'h80, 8'hD2};
    check_stream("ack", exp);
    check("ack sync latency", first_valid, 1);
    check("ack pops", pops, 0);
    check("ack eop", saw_eop, 1);
    check("ack tx_error", bus.tx_error, 0);

    // DATA0 with 01 02 03
    pay = '{8'h01, 8'h02, 8'h03};
    c = crc_model(pay);
    fifo = pay;
`ifndef TX_CRC_GEN_EN
    fifo.push_back(~c[7:0]);
    fifo.push_back(~c[15:8]);
`endif
    run_pkt(PKT_DATA0, -1, -1, 0, -1);
    check("data0 done", timed_out, 0);
    exp = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, ~c[7:0], ~c[15:8]};
    check_stream("data0", exp);
`ifdef TX_CRC_GEN_EN
    check("data0 pops", pops, 3);
`else
    check("data0 pops", pops, 5);
`endif
    check("data0 tx_error", bus.tx_error, 0);

    // DATA1 zero-length
    fifo.delete();
`ifndef TX_CRC_GEN_EN
    fifo = '{8'h00, 8'h00};
`endif
    run_pkt(PKT_DATA1, -1, -1, 0, -1);
    check("zlp done", timed_out, 0);
    exp = '{8'h80, 8'h4B, 8'h00, 8'h00};
    check_stream("zlp", exp);
`ifdef TX_CRC_GEN_EN
    check("zlp pops", pops, 0);
`else
    check("zlp pops", pops, 2);
`endif
    check("zlp eop", saw_eop, 1);

    // Invalid packet type
    fifo.delete();
    run_pkt(4'hF, -1, -1, 0, -1);
    check("inv done", timed_out, 0);
    check("inv bytes", got.size(), 0);
    check("inv byte_valid", saw_valid, 0);
    check("inv send_eop", saw_eop, 1);
    check("inv err seen", err_seen, 1);
    check("inv err sticky", bus.tx_error, 1);

    // Next valid request clears the error
    run_pkt(PKT_NAK, -1, -1, 0, -1);
    check("nak done", timed_out, 0);
    exp = '{8'h80, 8'h5A};
    check_stream("nak", exp);
    check("nak clears err", bus.tx_error, 0);

    // Occupancy snapshot one above the limit
    fifo.delete();
    run_pkt(PKT_DATA0, LIMIT + 1, -1, 0, -1);
    check("big done", timed_out, 0);
    check("big byte_valid", saw_valid, 0);
    check("big tx_error", bus.tx_error, 1);

`ifndef TX_CRC_GEN_EN
    // Fewer than the two host CRC bytes
    fifo = '{8'h00};
    run_pkt(PKT_DATA1, -1, -1, 0, -1);
    check("short done", timed_out, 0);
    check("short byte_valid", saw_valid, 0);
    check("short tx_error", bus.tx_error, 1);
`endif

    // Underrun after 2 of 5 payload bytes
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    c = crc_model(pay);
    fifo = pay;
`ifndef TX_CRC_GEN_EN
    fifo.push_back(~c[7:0]);
    fifo.push_back(~c[15:8]);
`endif
    run_pkt(PKT_DATA0, -1, 2, 0, -1);
    check("urun done", timed_out, 0);
    exp = '{8'h80, 8'hC3, 8'h10, 8'h20};
    check_stream("urun", exp);
    check("urun pops", pops, 2);
    check("urun eop", saw_eop, 1);
    check("urun tx_error", bus.tx_error, 1);

    // tx_start pulsed mid-DATA is ignored
    pay = '{8'hA5, 8'h5A, 8'hFF};
    c = crc_model(pay);
    fifo = pay;
`ifndef TX_CRC_GEN_EN
    fifo.push_back(~c[7:0]);
    fifo.push_back(~c[15:8]);
`endif
    run_pkt(PKT_DATA1, -1, -1, 1, -1);
    check("mid done", timed_out, 0);
    exp = '{8'h80, 8'h4B, 8'hA5, 8'h5A, 8'hFF, ~c[7:0], ~c[15:8]};
    check_stream("mid", exp);
    check("mid tx_error", bus.tx_error, 0);

    // Reset asserted in DATA aborts without EOP
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fifo = pay;
    run_pkt(PKT_DATA0, -1, -1, 0, 3);
    @(negedge clk);
    check("mrst tx_byte", bus.tx_byte, 8'h00);
    check("mrst byte_valid", bus.byte_valid, 1'b0);
    check("mrst get_tx_data", bus.get_tx_data, 1'b0);
    check("mrst send_eop", bus.send_eop, 1'b0);
    check("mrst active", bus.tx_trans_active, 1'b0);
    check("mrst tx_error", bus.tx_error, 1'b0);
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.send_eop || bus.tx_trans_active || bus.byte_valid) idle_bad = 1;
    end
    check("mrst stays idle", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
